// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the alu dispatch logic.
//   OPW                 - opcode width (matches the alu OpCode input)
//   OP_ADD..OP_DIV      - opcode encodings understood by the alu
//   ALU_LATENCY_DEFAULT - default alu latency in clk cycles
//   alu_req_t           - one queued request {a, b, op}
package alu_pkg;

    localparam int unsigned OPW = 2;

    localparam logic [OPW-1:0] OP_ADD = 2'b00;
    localparam logic [OPW-1:0] OP_SUB = 2'b01;
    localparam logic [OPW-1:0] OP_MUL = 2'b10;
    localparam logic [OPW-1:0] OP_DIV = 2'b11;

    localparam int unsigned ALU_LATENCY_DEFAULT = 1;

    typedef struct packed {
        logic [31:0]    a;
        logic [31:0]    b;
        logic [OPW-1:0] op;
    } alu_req_t;

    localparam int unsigned REQ_W = $bits(alu_req_t);

endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: synchronous request FIFO, DEPTH entries of WIDTH bits, no bypass.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset (empties the FIFO)
//   push, wdata   - write request/data; ignored when full
//   pop           - remove the head entry; ignored when empty
//   rdata         - head entry (valid when !empty)
//   full, empty   - occupancy flags
module dispatch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: issue stage in front of a handshake-less fixed-latency fp alu.
// Requests are queued, issued one at a time, and the alu result is held on a
// valid/ready output until taken.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   in_valid/in_ready/in_a/in_b/in_op - request handshake and payload
//   alu_a/alu_b/alu_op              - registered alu operands/opcode
//   alu_o                           - alu result
//   out_valid/out_ready/out_data/out_op - result handshake and payload
//   busy                            - queue non-empty or an operation in progress
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ALU_LATENCY = ALU_LATENCY_DEFAULT,
    parameter int unsigned OPW         = alu_pkg::OPW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_a,
    input  logic [31:0]    in_b,
    input  logic [OPW-1:0] in_op,
    output logic [31:0]    alu_a,
    output logic [31:0]    alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [31:0]    alu_o,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data,
    output logic [OPW-1:0] out_op,
    output logic           busy
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    alu_a_q, alu_a_d;
    logic [31:0]    alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic [31:0]    out_data_q, out_data_d;
    logic [OPW-1:0] out_op_q, out_op_d;

    alu_req_t push_req, head_req;
    logic     fifo_full, fifo_empty, issue;

    assign push_req.a  = in_a;
    assign push_req.b  = in_b;
    assign push_req.op = in_op;

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .wdata (push_req),
        .pop   (issue),
        .rdata (head_req),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        out_data_d = out_data_q;
        out_op_d   = out_op_q;
        issue      = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    issue = 1'b1;
                end
            end
            StWait: begin
                // cnt==1 means alu_o is valid at the coming edge.
                if (cnt_q == CW'(1)) begin
                    out_data_d = alu_o;
                    out_op_d   = alu_op_q;
                    state_d    = StHold;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        issue = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // The alu inputs only ever change here, so they never toggle spuriously.
        if (issue) begin
            alu_a_d  = head_req.a;
            alu_b_d  = head_req.b;
            alu_op_d = head_req.op;
            cnt_d    = CW'(ALU_LATENCY);
            state_d  = StWait;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            out_data_q <= '0;
            out_op_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            out_data_q <= out_data_d;
            out_op_q   <= out_op_d;
        end
    end

    assign in_ready  = !fifo_full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign out_valid = (state_q == StHold);
    assign out_data  = out_data_q;
    assign out_op    = out_op_q;
    assign busy      = !fifo_empty || (state_q != StIdle);

endmodule
